// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: queues LCD message codes and shows each for a minimum dwell time,
// gated by LCD init completion.
module lcd_msg_scheduler #(
    parameter int unsigned DWELL_CYCLES = 800000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  IDLE_MSG     = 8'h00,
    parameter logic [7:0]  BLANK_MSG    = 8'hFF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_finish_init,
    input  logic                         i_req_valid,
    input  logic [7:0]                   i_req_code,
    output logic                         o_req_ready,
    output logic [7:0]                   o_message,
    output logic                         o_busy,
    output logic                         o_drop,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DWELL_CYCLES);

    typedef enum logic [1:0] {S_BLANK, S_IDLE, S_SHOW} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    msg_nxt;
    logic          empty, expire, refresh, push, pop;

    assign empty        = level == '0;
    assign o_req_ready  = level != (AW+1)'(FIFO_DEPTH);
    assign expire       = cnt == CW'(DWELL_CYCLES - 1);
    // Re-requesting the code already on screen extends its dwell instead of queueing a duplicate
    assign refresh      = state == S_SHOW && i_finish_init && empty && i_req_valid && i_req_code == o_message;
    assign push         = i_req_valid && o_req_ready && !refresh;
    assign o_busy       = state == S_SHOW;
    assign o_fifo_level = level;

    always_comb begin
        state_nxt = state;
        msg_nxt   = o_message;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        if (!i_finish_init) begin
            state_nxt = S_BLANK;
            msg_nxt   = BLANK_MSG;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_BLANK: begin
                    state_nxt = S_IDLE;
                    msg_nxt   = IDLE_MSG;
                end
                S_IDLE: if (!empty) begin
                    pop       = 1'b1;
                    msg_nxt   = mem[rd_ptr];
                    cnt_nxt   = '0;
                    state_nxt = S_SHOW;
                end
                S_SHOW: begin
                    if (refresh) cnt_nxt = '0;
                    else if (expire && !empty) begin
                        pop     = 1'b1;
                        msg_nxt = mem[rd_ptr];
                        cnt_nxt = '0;
                    end else if (expire) begin
                        msg_nxt   = IDLE_MSG;
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else cnt_nxt = cnt + 1'b1;
                end
                default: begin
                    state_nxt = S_BLANK;
                    msg_nxt   = BLANK_MSG;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_BLANK;
            o_message <= BLANK_MSG;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            o_drop    <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_message <= msg_nxt;
            cnt       <= cnt_nxt;
            o_drop    <= i_req_valid && !o_req_ready;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level     <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_req_code;
    end
endmodule

// File: doc/lcd_msg_scheduler.md
# lcd_msg_scheduler

Upstream neighbour of the LCD controller: collects message-code requests from the dehazing pipeline and control logic, queues them, and drives the controller's 8-bit message input. Each code is held on the display for a guaranteed minimum dwell time before the next queued code replaces it. Outputs the blank code until the controller reports initialisation complete, and reverts to an idle code when the queue drains.

## Interface
- DWELL_CYCLES, 800000: minimum cycles each queued code stays on `o_message` (1 s at 800 kHz); must be ≥ 2.
- FIFO_DEPTH, 4: request queue entries; power of two, ≥ 2.
- IDLE_MSG, 8'h00: code shown when the queue is empty and no code is dwelling.
- BLANK_MSG, 8'hFF: all-clear code shown before LCD init completes.

Ports:
- i_clk  in  1  single clock (800 kHz LCD domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_finish_init  in  1  LCD controller init-done flag.
- i_req_valid  in  1  request strobe.
- i_req_code  in  8  message code to display.
- o_req_ready  out  1  `~full`, registered-state derived; a request is accepted on an edge where `i_req_valid & o_req_ready`.
- o_message  out  8  registered code to the LCD controller's message input.
- o_busy  out  1  high in S_SHOW.
- o_drop  out  1  one-cycle pulse after an edge where `i_req_valid & ~o_req_ready`.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
States:
- **S_BLANK** (reset state)
  - `o_message` = BLANK_MSG.
  - Requests are accepted and queued.
  - `i_finish_init` = 1 → S_IDLE; `o_message` loads IDLE_MSG on the same edge.
- **S_IDLE**
  - `o_message` = IDLE_MSG.
  - If the queue is non-empty: pop the head into `o_message`, clear the dwell counter, go to S_SHOW.
- **S_SHOW**
  - The dwell counter increments each cycle.
  - At counter == DWELL_CYCLES-1:
    - Queue non-empty: pop the next code into `o_message`, clear the counter, stay in S_SHOW.
    - Queue empty: load IDLE_MSG, go to S_IDLE.
- From any state, `i_finish_init` = 0 → S_BLANK with `o_message` = BLANK_MSG. The queue is retained and the counter is cleared.

Refresh rule (S_SHOW only):
- Applies when the queue is empty and `i_req_valid` is high with `i_req_code == o_message`.
- The request is accepted but not enqueued, and the dwell counter is cleared to 0.
- Refresh takes priority over dwell expiry in the same cycle: the state stays in S_SHOW with counter 0.

Queue:
- Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH, plus an occupancy counter.
- Push and pop in the same cycle leave occupancy unchanged.
- When full, `o_req_ready` = 0 even if a pop occurs in that cycle. The request is dropped and `o_drop` pulses.
- Pop reads the head entry, which is never the entry being written that cycle.
- Occupancy never exceeds FIFO_DEPTH and never underflows.

Reset (asynchronous on `i_rst` high):
- state S_BLANK, `o_message` = BLANK_MSG.
- `o_busy` = 0, `o_drop` = 0, `o_fifo_level` = 0, `o_req_ready` = 1.
- pointers and dwell counter 0.
- Reset mid-dwell discards the queue and the current code.

## Timing
- Request accepted at edge k while in S_IDLE with an empty queue → code on `o_message` after edge k+1.
- Each popped code is held exactly DWELL_CYCLES cycles, unless refreshed (extended) or preempted by `i_finish_init` falling.
- Back-to-back queued codes change on consecutive dwell expiries with no IDLE_MSG gap.
- `o_busy` and `o_fifo_level` are registered-state outputs, so they change on the same edge as state and pointers.
- `o_drop` is registered: high for the cycle following the rejected request edge.
- `o_message` is glitch-free (register output); the LCD controller samples it freely.

## Test plan
Bench parameters: DWELL_CYCLES=10, FIFO_DEPTH=4.
- **Init gating:** hold `i_finish_init`=0, push 8'h05 → `o_message` stays 8'hFF and level=1. Raise `i_finish_init` at edge k → IDLE_MSG after k, 8'h05 after k+1, 8'h00 after a further 10 cycles.
- **Back-to-back:** after init, push 8'h01, 8'h02, 8'h03 on consecutive cycles → `o_message` shows 01, 02 and 03 for 10 cycles each with no 00 between them, then 00. `o_busy` falls on the same edge as the return to 00.
- **Overflow:** during dwell, push 6 codes back-to-back → first 4 accepted (`o_req_ready` drops once level=4), 2 `o_drop` pulses, level=4. The accepted codes display in order.
- **Refresh:** show 8'h07 and, at dwell cycle 9 (expiry cycle), push 8'h07 with the queue empty → counter resets and 07 is held 10 more cycles. Pushing 8'h08 instead → enqueued, displayed after expiry.
- **Pointer wrap:** push/pop 9 codes (0x10–0x18) through the depth-4 queue → all shown in order, level returns to 0.
- **Reset and init loss mid-operation:** assert `i_rst` mid-dwell with level=2 → `o_message`=8'hFF and level=0 immediately. Separately, dropping `i_finish_init` mid-dwell → 8'hFF next edge with the queue retained; re-raising it resumes from the queue head.
